// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg : state encodings shared by the configuration-packet UART receiver
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } char_state_t;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } pkt_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ----------------------------------------------------------------------------
// uart_rx_sync : two-flop line synchronizer with falling-edge detect
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic fall
);

    // [1:0] form the synchronizer, [2] holds the previous synchronized value
    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], din};
        end
    end

    assign dout = sync_q[1];
    assign fall = sync_q[2] & ~sync_q[1];

endmodule

`default_nettype wire

// File: rtl/uart_conf_rx.sv
// ----------------------------------------------------------------------------
// uart_conf_rx : UART receiver that loads a sync-headed, XOR-checked parameter packet
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_conf_rx
    import uart_pkg::*;
#(
    parameter int                CLK_PER_BIT = 52,
    parameter int                DATA_W      = 8,
    parameter int                PAR_NUM     = 5,
    parameter int                PARITY_EN   = 0,
    parameter logic [DATA_W-1:0] SYNC_WORD   = 'hA5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      uart_data,
    output logic [PAR_NUM*DATA_W-1:0] conf_par,
    output logic                      conf_valid,
    output logic                      frame_err,
    output logic                      chk_err
);

    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam int BIT_W = $clog2(DATA_W);
    localparam int IDX_W = (PAR_NUM > 1) ? $clog2(PAR_NUM) : 1;

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAR_NUM - 1);

    logic rx;
    logic rx_fall;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (uart_data),
        .dout  (rx),
        .fall  (rx_fall)
    );

    char_state_t        cstate_q, cstate_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               par_err_q, par_err_d;
    logic               char_valid_q, char_valid_d;
    logic               frame_err_q, frame_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cstate_q     <= IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            data_q       <= '0;
            par_err_q    <= 1'b0;
            char_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            cstate_q     <= cstate_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            data_q       <= data_d;
            par_err_q    <= par_err_d;
            char_valid_q <= char_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        cstate_d     = cstate_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        data_d       = data_q;
        par_err_d    = par_err_q;
        char_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (cstate_q)
            IDLE: begin
                if (rx_fall) begin
                    cnt_d     = HALF_CNT;
                    par_err_d = 1'b0;
                    cstate_d  = START;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    if (!rx) begin
                        cnt_d    = FULL_CNT;
                        bit_d    = '0;
                        cstate_d = DATA;
                    end else begin
                        cstate_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    data_d = {rx, data_q[DATA_W-1:1]};
                    cnt_d  = FULL_CNT;
                    if (bit_q == LAST_BIT) begin
                        cstate_d = (PARITY_EN != 0) ? PAR : STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            PAR: begin
                if (cnt_q == '0) begin
                    par_err_d = rx ^ (^data_q);
                    cnt_d     = FULL_CNT;
                    cstate_d  = STOP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    if (!rx || par_err_q) begin
                        frame_err_d = 1'b1;
                    end else begin
                        char_valid_d = 1'b1;
                    end
                    cstate_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: cstate_d = IDLE;
        endcase
    end

    // Packet layer: data_q stays stable while char_valid_q is high
    pkt_state_t                 pstate_q, pstate_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [DATA_W-1:0]          xor_q, xor_d;
    logic [PAR_NUM*DATA_W-1:0]  shadow_q, shadow_d;
    logic [PAR_NUM*DATA_W-1:0]  conf_q, conf_d;
    logic                       conf_valid_q, conf_valid_d;
    logic                       chk_err_q, chk_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pstate_q     <= HUNT;
            idx_q        <= '0;
            xor_q        <= '0;
            shadow_q     <= '0;
            conf_q       <= '0;
            conf_valid_q <= 1'b0;
            chk_err_q    <= 1'b0;
        end else begin
            pstate_q     <= pstate_d;
            idx_q        <= idx_d;
            xor_q        <= xor_d;
            shadow_q     <= shadow_d;
            conf_q       <= conf_d;
            conf_valid_q <= conf_valid_d;
            chk_err_q    <= chk_err_d;
        end
    end

    always_comb begin
        pstate_d     = pstate_q;
        idx_d        = idx_q;
        xor_d        = xor_q;
        shadow_d     = shadow_q;
        conf_d       = conf_q;
        conf_valid_d = 1'b0;
        chk_err_d    = 1'b0;
        if (frame_err_q) begin
            pstate_d = HUNT;
        end else if (char_valid_q) begin
            case (pstate_q)
                HUNT: begin
                    if (data_q == SYNC_WORD) begin
                        idx_d    = '0;
                        xor_d    = '0;
                        pstate_d = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    shadow_d[int'(idx_q)*DATA_W +: DATA_W] = data_q;
                    xor_d = xor_q ^ data_q;
                    if (idx_q == LAST_IDX) begin
                        pstate_d = CHECK;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                CHECK: begin
                    if (data_q == xor_q) begin
                        conf_d       = shadow_q;
                        conf_valid_d = 1'b1;
                    end else begin
                        chk_err_d = 1'b1;
                    end
                    pstate_d = HUNT;
                end
                default: pstate_d = HUNT;
            endcase
        end
    end

    assign conf_par   = conf_q;
    assign conf_valid = conf_valid_q;
    assign frame_err  = frame_err_q;
    assign chk_err    = chk_err_q;

endmodule

`default_nettype wire

// File: doc/uart_conf_rx.md
UART_CONF_RX -- requirements
Module: uart_conf_rx

Interface
REQ-001 The parameter CLK_PER_BIT SHALL default to 52 and SHALL set the number of clk cycles per UART bit (minimum 4).
REQ-002 The parameter DATA_W SHALL default to 8 and SHALL set the number of data bits per UART character (range 5..9).
REQ-003 The parameter PAR_NUM SHALL default to 5 and SHALL set the number of configuration parameters per packet (range 1..16).
REQ-004 The parameter PARITY_EN SHALL default to 0 and, when 1, SHALL enable one even-parity bit after the data bits.
REQ-005 The parameter SYNC_WORD SHALL default to 'hA5 and SHALL be the DATA_W-bit packet header value.
REQ-006 The port clk SHALL be an input, 1 bit wide, and SHALL be the single clock; all logic SHALL be rising-edge triggered.
REQ-007 The port rst_n SHALL be an input, 1 bit wide, and SHALL be the reset, asynchronous and active-low.
REQ-008 The port uart_data SHALL be an input, 1 bit wide, carrying the asynchronous serial line, which idles high.
REQ-009 The port conf_par SHALL be an output, PAR_NUM*DATA_W bits wide; parameter k SHALL occupy bits [k*DATA_W +: DATA_W].
REQ-010 The port conf_valid SHALL be an output, 1 bit wide, giving a 1-cycle pulse when conf_par is updated.
REQ-011 The port frame_err SHALL be an output, 1 bit wide, giving a 1-cycle pulse on a bad stop bit or parity bit.
REQ-012 The port chk_err SHALL be an output, 1 bit wide, giving a 1-cycle pulse on a packet checksum mismatch.

Function
REQ-013 uart_data SHALL pass through a 2-flop synchronizer; the falling edge SHALL be detected on the synchronized signal.
REQ-014 The character FSM SHALL have the states IDLE, START, DATA, PAR and STOP.
REQ-015 In IDLE, a falling edge SHALL load the bit counter with CLK_PER_BIT/2-1 and enter START.
REQ-016 In START, at counter zero the line SHALL be sampled: if low, the FSM SHALL enter DATA with the counter set to CLK_PER_BIT-1; if high (glitch), it SHALL return to IDLE with no error.
REQ-017 In DATA, DATA_W bits SHALL be sampled LSB-first, one sample every CLK_PER_BIT cycles; after the last bit the FSM SHALL enter PAR if PARITY_EN=1, otherwise STOP.
REQ-018 In PAR, the sampled bit XOR the data bits SHALL be 0; otherwise a parity failure SHALL be flagged.
REQ-019 In STOP, the sampled line SHALL be high; if the stop bit is low or parity failed, frame_err SHALL pulse, the character SHALL be dropped, the packet FSM SHALL return to HUNT, and the FSM SHALL enter IDLE.
REQ-020 A good character SHALL produce an internal 1-cycle char_valid in the cycle after the stop-bit sample.
REQ-021 The packet FSM SHALL have the states HUNT, PAYLOAD and CHECK.
REQ-022 In HUNT, a character equal to SYNC_WORD SHALL enter PAYLOAD and clear the index and running XOR; any other character SHALL be ignored.
REQ-023 In PAYLOAD, character i SHALL be written into shadow slot i (0..PAR_NUM-1) and XORed into the running checksum; after slot PAR_NUM-1 the FSM SHALL enter CHECK.
REQ-024 In CHECK, if the received character equals the running XOR, the shadow SHALL be copied to conf_par in a single cycle and conf_valid SHALL pulse in that same cycle; otherwise chk_err SHALL pulse and conf_par SHALL remain unchanged.
REQ-025 After CHECK, the packet FSM SHALL return to HUNT in all cases.
REQ-026 A SYNC_WORD value arriving in PAYLOAD or CHECK SHALL be treated as data and SHALL NOT resynchronize.
REQ-027 conf_par SHALL never expose a partially written packet.
REQ-028 conf_valid, frame_err and chk_err SHALL be mutually exclusive within any cycle.

Reset
REQ-029 While rst_n=0, conf_par, the shadow slots, the checksum and all counters SHALL be 0, the FSMs SHALL be in IDLE and HUNT, the synchronizer flops SHALL be 1, and all pulse outputs SHALL be 0.
REQ-030 Reset asserted mid-character or mid-packet SHALL discard all partial data; the first frame after release SHALL require a fresh falling edge.

Structure
REQ-031 The state enums (char_state_t, pkt_state_t) SHALL live in a shared package, uart_pkg.
REQ-032 The synchronizer and falling-edge detector SHALL be one sub-module, uart_rx_sync, with ports clk, rst_n, din, dout and fall.

Verification
REQ-033 The bench SHALL cover the default parameters: frames A5,01,02,03,04,05,01 -> conf_par={05,04,03,02,01}, and conf_valid pulses once.
REQ-034 The bench SHALL cover a bad checksum: frames A5,01,02,03,04,05,00 -> chk_err pulses once and conf_par keeps its prior value.
REQ-035 The bench SHALL cover a bad stop bit: the stop bit of the 3rd payload character is forced low -> frame_err pulses, then a valid packet is accepted normally.
REQ-036 The bench SHALL cover a glitch: a 10-cycle low pulse on the idle line -> no error pulses and no character is received.
REQ-037 The bench SHALL cover PARITY_EN=1 with CLK_PER_BIT=16: one character with flipped parity -> frame_err pulses; the packet is resent correctly -> conf_valid pulses.
REQ-038 The bench SHALL cover reset mid-packet: rst_n is asserted after 3 payload characters -> conf_par=0, and the next complete packet loads correctly.
